// File: rtl/yuv2rgb_if.sv
// ---------------------------------------------------------------------------
// yuv2rgb_if
// Pixel request/result bundle for the sequential YUV-to-RGB converter.
//   start      : conversion request, sampled only while the converter is idle
//   inportY    : luma, unsigned BITS-wide
//   inportU/V  : chroma, two's complement BITS-wide
//   outportR/G/B : clamped 0..255 colour components on BITS-wide ports
//   busy       : high while a conversion is in flight
//   done       : one-cycle pulse when outportR/G/B carry a fresh result
// The master drives requests (pixel source); the slave is the converter.
// ---------------------------------------------------------------------------
interface yuv2rgb_if #(
  parameter int BITS = 9
);
  logic            start;
  logic [BITS-1:0] inportY;
  logic [BITS-1:0] inportU;
  logic [BITS-1:0] inportV;
  logic [BITS-1:0] outportR;
  logic [BITS-1:0] outportG;
  logic [BITS-1:0] outportB;
  logic            busy;
  logic            done;

  modport master (
    output start, inportY, inportU, inportV,
    input  outportR, outportG, outportB, busy, done
  );

  modport slave (
    input  start, inportY, inportU, inportV,
    output outportR, outportG, outportB, busy, done
  );
endinterface

// File: rtl/yuv2rgb_seq.sv
// ---------------------------------------------------------------------------
// yuv2rgb_seq
// Sequential inverse colour-space converter (YUV -> RGB). A start request in
// IDLE captures one pixel; four multiply states share a single signed
// multiplier to form the chroma products, and a final SUM state rounds,
// clamps and registers R/G/B while pulsing done. One pixel per 6 cycles.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset (discards any in-flight pixel)
//   bus  : yuv2rgb_if slave modport
//            start, inportY (unsigned), inportU/inportV (signed)  -> inputs
//            outportR/G/B (0..255), busy, done                     -> outputs
// ---------------------------------------------------------------------------
module yuv2rgb_seq #(
  parameter int BITS = 9,
  parameter int FRAC = 8,
  parameter int C_RV = 292,
  parameter int C_GU = 101,
  parameter int C_GV = 149,
  parameter int C_BU = 520
) (
  input  logic       clk,
  input  logic       rst,
  yuv2rgb_if.slave   bus
);

  // 20-bit signed accumulator holds (Y<<8) plus/minus any chroma product.
  localparam int ACC_W = 20;
  // Coefficients are unsigned but fed to a signed multiplier, so one spare
  // bit keeps the largest (520) positive.
  localparam int CW    = 12;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC-1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(255);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    SUM  = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   latch_en;

  // Captured pixel
  logic        [BITS-1:0]  y_p0;
  logic signed [BITS-1:0]  u_p0;
  logic signed [BITS-1:0]  v_p0;

  // Chroma products
  logic signed [ACC_W-1:0] prod_rv_p1;
  logic signed [ACC_W-1:0] prod_gu_p1;
  logic signed [ACC_W-1:0] prod_gv_p1;
  logic signed [ACC_W-1:0] prod_bu_p1;

  // Registered results
  logic        [BITS-1:0]  r_p2;
  logic        [BITS-1:0]  g_p2;
  logic        [BITS-1:0]  b_p2;
  logic                    vld_p2;

  // Shared multiplier operands
  logic signed [CW-1:0]    mul_coef;
  logic signed [BITS-1:0]  mul_op;
  logic signed [ACC_W-1:0] coef_x;
  logic signed [ACC_W-1:0] op_x;
  logic signed [ACC_W-1:0] mul_prod;

  // SUM-state arithmetic
  logic signed [ACC_W-1:0] y_s;
  logic signed [ACC_W-1:0] r_raw;
  logic signed [ACC_W-1:0] g_raw;
  logic signed [ACC_W-1:0] b_raw;
  logic        [BITS-1:0]  r_sat;
  logic        [BITS-1:0]  g_sat;
  logic        [BITS-1:0]  b_sat;

  // Round half-up, then arithmetic shift right by FRAC (floor for negatives).
  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] x
  );
    return (x + HALF) >>> FRAC;
  endfunction

  // Clamp a signed value into 0..255 on a BITS-wide unsigned port.
  function automatic logic [BITS-1:0] sat_u8(
    input logic signed [ACC_W-1:0] x
  );
    if (x[ACC_W-1])
      return '0;
    if (x > MAXV)
      return BITS'(MAXV);
    return BITS'(x);
  endfunction

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch_en  = 1'b1;
          state_nxt = MUL0;
        end
      end
      MUL0:    state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = MUL3;
      MUL3:    state_nxt = SUM;
      SUM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selection for the single multiplier: one product per MUL state.
  always_comb begin
    mul_coef = '0;
    mul_op   = '0;
    case (state)
      MUL0: begin
        mul_coef = CW'(C_RV);
        mul_op   = v_p0;
      end
      MUL1: begin
        mul_coef = CW'(C_GU);
        mul_op   = u_p0;
      end
      MUL2: begin
        mul_coef = CW'(C_GV);
        mul_op   = v_p0;
      end
      MUL3: begin
        mul_coef = CW'(C_BU);
        mul_op   = u_p0;
      end
      default: begin
        mul_coef = '0;
        mul_op   = '0;
      end
    endcase
  end

  assign coef_x   = ACC_W'(mul_coef);
  assign op_x     = ACC_W'(mul_op);
  assign mul_prod = coef_x * op_x;

  // ---------------------------------------------------------------------
  // Stage p0: pixel capture on an accepted start
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_p0 <= '0;
      u_p0 <= '0;
      v_p0 <= '0;
    end else if (latch_en) begin
      y_p0 <= bus.inportY;
      u_p0 <= $signed(bus.inportU);
      v_p0 <= $signed(bus.inportV);
    end
  end

  // ---------------------------------------------------------------------
  // Stage p1: chroma products, one per MUL state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_rv_p1 <= '0;
      prod_gu_p1 <= '0;
      prod_gv_p1 <= '0;
      prod_bu_p1 <= '0;
    end else begin
      case (state)
        MUL0:    prod_rv_p1 <= mul_prod;
        MUL1:    prod_gu_p1 <= mul_prod;
        MUL2:    prod_gv_p1 <= mul_prod;
        MUL3:    prod_bu_p1 <= mul_prod;
        default: ;
      endcase
    end
  end

  // Luma is unsigned over all BITS, so zero-extend before scaling.
  assign y_s   = $signed(ACC_W'(y_p0)) <<< FRAC;
  assign r_raw = y_s + prod_rv_p1;
  assign g_raw = y_s - prod_gu_p1 - prod_gv_p1;
  assign b_raw = y_s + prod_bu_p1;

  assign r_sat = sat_u8(round_shift(r_raw));
  assign g_sat = sat_u8(round_shift(g_raw));
  assign b_sat = sat_u8(round_shift(b_raw));

  // ---------------------------------------------------------------------
  // Stage p2: result registers, loaded only in SUM so they never show
  // partial sums and hold their value between done pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= (state == SUM);
      if (state == SUM) begin
        r_p2 <= r_sat;
        g_p2 <= g_sat;
        b_p2 <= b_sat;
      end
    end
  end

  assign bus.outportR = r_p2;
  assign bus.outportG = g_p2;
  assign bus.outportB = b_p2;
  assign bus.done     = vld_p2;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_yuv2rgb_seq.sv
// ---------------------------------------------------------------------------
// tb_yuv2rgb_seq
// Self-checking bench for yuv2rgb_seq: directed colour vectors, reset and
// handshake corner cases, then randomized pixels against a floating-point
// free integer reference of the YUV->RGB equations.
// ---------------------------------------------------------------------------
module tb_yuv2rgb_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  yuv2rgb_if #(.BITS(9)) bus();

  yuv2rgb_seq #(.BITS(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Floor division by 256 for signed integers.
  function automatic int floor256(input int n);
    if (n >= 0)
      return n / 256;
    return -((-n + 255) / 256);
  endfunction

  function automatic int clamp255(input int n);
    if (n < 0)   return 0;
    if (n > 255) return 255;
    return n;
  endfunction

  // Reference: R = Y + 1.140V, G = Y - 0.395U - 0.581V, B = Y + 2.032U in
  // 8-bit fixed point, rounded half-up then clamped.
  task automatic ref_pix(input logic [8:0] y, input logic [8:0] u,
                         input logic [8:0] v,
                         output int r, output int g, output int b);
    int yi, ui, vi;
    yi = int'(y);
    ui = int'($signed(u));
    vi = int'($signed(v));
    r = clamp255(floor256(yi * 256 + 292 * vi + 128));
    g = clamp255(floor256(yi * 256 - 101 * ui - 149 * vi + 128));
    b = clamp255(floor256(yi * 256 + 520 * ui + 128));
  endtask

  // Runs one conversion starting #1 after a clock edge with the DUT idle.
  // scramble: change inputs right after the start edge.
  // poke: toggle start while busy (must be ignored, never queued).
  task automatic run_pixel(input string tag, input logic [8:0] y,
                           input logic [8:0] u, input logic [8:0] v,
                           input bit scramble, input bit poke);
    int er, eg, eb;
    ref_pix(y, u, v, er, eg, eb);
    bus.inportY = y;
    bus.inportU = u;
    bus.inportV = v;
    bus.start   = 1'b1;
    @(posedge clk); #1;                      // edge 0
    bus.start = 1'b0;
    check_val({tag, ".busy0"}, 32'(bus.busy), 32'd1);
    if (scramble) begin
      bus.inportY = 9'($urandom);
      bus.inportU = 9'($urandom);
      bus.inportV = 9'($urandom);
    end
    if (poke) bus.start = 1'($urandom);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;                    // edge k
      if (k < 5) begin
        check_val({tag, ".busy"}, 32'(bus.busy), 32'd1);
        check_val({tag, ".done_early"}, 32'(bus.done), 32'd0);
        if (poke) bus.start = (k == 4) ? 1'b1 : 1'($urandom);
      end else begin
        bus.start = 1'b0;
        check_val({tag, ".done"}, 32'(bus.done), 32'd1);
        check_val({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        check_val({tag, ".R"}, 32'(bus.outportR), 32'(er));
        check_val({tag, ".G"}, 32'(bus.outportG), 32'(eg));
        check_val({tag, ".B"}, 32'(bus.outportB), 32'(eb));
      end
    end
    @(posedge clk); #1;                      // edge 6
    check_val({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check_val({tag, ".no_queue"}, 32'(bus.busy), 32'd0);
    check_val({tag, ".R_hold"}, 32'(bus.outportR), 32'(er));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int done_edge[$];
    bus.start   = 1'b0;
    bus.inportY = '0;
    bus.inportU = '0;
    bus.inportV = '0;

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    check_val("rst.R", 32'(bus.outportR), 32'd0);
    check_val("rst.G", 32'(bus.outportG), 32'd0);
    check_val("rst.B", 32'(bus.outportB), 32'd0);
    check_val("rst.busy", 32'(bus.busy), 32'd0);
    check_val("rst.done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    run_pixel("grey",     9'd128, 9'd0,   9'd0,   1'b0, 1'b0);
    run_pixel("red",      9'd100, 9'd0,   9'd100, 1'b0, 1'b0);
    run_pixel("upclamp",  9'd255, 9'd0,   9'd127, 1'b0, 1'b0);
    run_pixel("loclamp",  9'd0,   9'h19C, 9'd0,   1'b0, 1'b0);
    run_pixel("latch",    9'd100, 9'd0,   9'd100, 1'b1, 1'b0);
    run_pixel("busystart",9'd128, 9'd0,   9'd0,   1'b0, 1'b1);
    run_pixel("bigY",     9'd511, 9'h100, 9'h100, 1'b0, 1'b0);

    // start held high for 12 edges -> conversions at edges 0 and 6
    bus.inportY = 9'd128;
    bus.inportU = 9'd0;
    bus.inportV = 9'd0;
    bus.start   = 1'b1;
    done_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (e == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_edge.push_back(e);
      end
    end
    check_val("hold.count", 32'(done_cnt), 32'd2);
    check_val("hold.edge0", 32'(done_edge.size() > 0 ? done_edge[0] : -1), 32'd5);
    check_val("hold.edge1", 32'(done_edge.size() > 1 ? done_edge[1] : -1), 32'd11);
    check_val("hold.R", 32'(bus.outportR), 32'd128);

    // Mid-run asynchronous reset
    bus.inportY = 9'd100;
    bus.inportU = 9'd0;
    bus.inportV = 9'd100;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("midrst.busy_before", 32'(bus.busy), 32'd1);
    check_val("midrst.R_before", 32'(bus.outportR), 32'd128);
    #2 rst = 1'b1;
    #1;
    check_val("midrst.R", 32'(bus.outportR), 32'd0);
    check_val("midrst.G", 32'(bus.outportG), 32'd0);
    check_val("midrst.B", 32'(bus.outportB), 32'd0);
    check_val("midrst.busy", 32'(bus.busy), 32'd0);
    check_val("midrst.done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    check_val("idle.no_done", 32'(done_cnt), 32'd0);
    check_val("idle.busy", 32'(bus.busy), 32'd0);

    // Randomized pixels
    for (int i = 0; i < 40; i++) begin
      run_pixel("rand", 9'($urandom), 9'($urandom), 9'($urandom),
                1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
